seven_seg_scan_ctrl: RTL and testbench

//  Time-multiplexed digit scanner for N-digit common-anode 7-seg arrays. Cycles a digit index and
//  one-hot anode drive at a parametrised dwell rate. Inserts a blanking gap between digits to stop

---
 rtl/seven_seg_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scanner for common-anode 7-segment digit arrays.
// Drives one anode at a time, blanks between digits and skips masked-off digits.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGIT_CYCLES     = 200_000,
  parameter int BLANK_CYCLES     = 1_000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  localparam int SEL_W           = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  digit_strobe,
  output logic                  frame_tick
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [SEL_W-1:0]      sel_reg, sel_next;
  logic [NUM_DIGITS-1:0] anode_reg, anode_next;
  logic                  strobe_reg, strobe_next;
  logic                  frame_reg, frame_next;
  logic                  advance;

  logic [NUM_DIGITS-1:0]       above, above_oh, first_oh, pick_oh, sel_dec;
  logic [SEL_W*NUM_DIGITS-1:0] enc_terms;
  logic [SEL_W-1:0]            pick_idx;
  logic                        wrap;

  // Next digit = lowest enabled index above sel; if none, wrap to lowest enabled overall.
  assign first_oh = digit_mask & (~digit_mask + NUM_DIGITS'(1));
  assign above_oh = above & (~above + NUM_DIGITS'(1));
  assign wrap     = ~|above;
  assign pick_oh  = (wrap || state_reg == IDLE) ? first_oh : above_oh;

  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign above[gi] = 1'b0;
      end else begin : g_rest
        assign above[gi] = digit_mask[gi] & (sel_reg < SEL_W'(gi));
      end
      assign sel_dec[gi] = (sel_next == SEL_W'(gi));
    end
    for (gb = 0; gb < SEL_W; gb++) begin : g_enc_bit
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc_term
        if (((gi >> gb) & 1) != 0) begin : g_set
          assign enc_terms[gb*NUM_DIGITS + gi] = pick_oh[gi];
        end else begin : g_clr
          assign enc_terms[gb*NUM_DIGITS + gi] = 1'b0;
        end
      end
      assign pick_idx[gb] = |enc_terms[gb*NUM_DIGITS +: NUM_DIGITS];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + CNT_W'(1);
    sel_next    = sel_reg;
    strobe_next = 1'b0;
    frame_next  = 1'b0;
    advance     = 1'b0;
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          if (|digit_mask) begin
            state_next  = ON;
            sel_next    = pick_idx;
            strobe_next = 1'b1;
            frame_next  = 1'b1;
          end
        end
        ON: begin
          if (cnt_reg == ON_LAST) begin
            if (BLANK_CYCLES > 0) begin
              state_next = BLANK;
              cnt_next   = '0;
            end else begin
              advance = 1'b1;
            end
          end
        end
        BLANK: begin
          if (cnt_reg == BLANK_LAST) advance = 1'b1;
        end
        default: state_next = IDLE;
      endcase
      if (advance) begin
        cnt_next = '0;
        if (|digit_mask) begin
          state_next  = ON;
          sel_next    = pick_idx;
          strobe_next = 1'b1;
          frame_next  = wrap;
        end else begin
          state_next = IDLE;
        end
      end
    end
  end

  // Mask is applied to the anode every ON cycle, so a cleared bit goes dark one clock later.
  assign anode_next = ((state_next == ON) ? (sel_dec & digit_mask) : '0) ^ ALL_OFF;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sel_reg    <= '0;
      anode_reg  <= ALL_OFF;
      strobe_reg <= 1'b0;
      frame_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sel_reg    <= sel_next;
      anode_reg  <= anode_next;
      strobe_reg <= strobe_next;
      frame_reg  <= frame_next;
    end
  end

  assign sel          = sel_reg;
  assign anode        = anode_reg;
  assign digit_strobe = strobe_reg;
  assign frame_tick   = frame_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: three configurations checked every cycle against a
// time-into-period reference model, plus hand-computed scan patterns.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [3:0] mask;

  logic [1:0] sel_a, sel_b, sel_c;
  logic [3:0] anode_a, anode_b;
  logic [2:0] anode_c;
  logic       ds_a, ds_b, ds_c, ft_a, ft_b, ft_c;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_CYCLES(5), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(mask),
    .sel(sel_a), .anode(anode_a), .digit_strobe(ds_a), .frame_tick(ft_a));

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_CYCLES(5), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(mask),
    .sel(sel_b), .anode(anode_b), .digit_strobe(ds_b), .frame_tick(ft_b));

  seven_seg_scan_ctrl #(.NUM_DIGITS(3), .DIGIT_CYCLES(5), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(mask[2:0]),
    .sel(sel_c), .anode(anode_c), .digit_strobe(ds_c), .frame_tick(ft_c));

  // Model: a digit period is DC+BC clocks; t counts clocks since the digit was entered.
  typedef struct {
    bit active;
    int t;
    int sel;
    int on;
    bit ds;
    bit ft;
  } model_t;

  model_t m_a = '{0, 0, 0, 0, 0, 0};
  model_t m_b = '{0, 0, 0, 0, 0, 0};
  model_t m_c = '{0, 0, 0, 0, 0, 0};

  function automatic bit bit_set(int v, int i);
    return ((v >> i) & 1) != 0;
  endfunction

  function automatic model_t step(model_t m, bit r, bit e, int msk, int n, int dc, int bc);
    model_t x = m;
    int nxt;
    x.ds = 1'b0;
    x.ft = 1'b0;
    msk = msk & ((1 << n) - 1);
    if (!r) begin
      x.active = 1'b0; x.t = 0; x.sel = 0; x.on = 0;
    end else if (!e) begin
      x.active = 1'b0; x.t = 0; x.on = 0;
    end else if (!x.active) begin
      x.on = 0;
      if (msk != 0) begin
        nxt = -1;
        for (int k = n - 1; k >= 0; k--) if (bit_set(msk, k)) nxt = k;
        x.active = 1'b1; x.t = 0; x.sel = nxt; x.ds = 1'b1; x.ft = 1'b1;
        x.on = msk & (1 << nxt);
      end
    end else begin
      x.t = x.t + 1;
      if (x.t == dc + bc) begin
        nxt = -1;
        for (int k = n; k >= 1; k--) if (bit_set(msk, (m.sel + k) % n)) nxt = (m.sel + k) % n;
        if (nxt < 0) begin
          x.active = 1'b0; x.t = 0; x.on = 0;
        end else begin
          x.t = 0; x.sel = nxt; x.ds = 1'b1; x.ft = (nxt <= m.sel);
          x.on = msk & (1 << nxt);
        end
      end else begin
        x.on = (x.t < dc) ? (msk & (1 << x.sel)) : 0;
      end
    end
    return x;
  endfunction

  function automatic int exp_anode(model_t m, int n, bit al);
    return al ? ((~m.on) & ((1 << n) - 1)) : m.on;
  endfunction

  task automatic chk(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  always @(posedge clk) begin
    m_a <= step(m_a, rst_n, en, int'(mask), 4, 5, 2);
    m_b <= step(m_b, rst_n, en, int'(mask), 4, 5, 0);
    m_c <= step(m_c, rst_n, en, int'(mask), 3, 5, 2);
    check_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("a_sel", sel_a, m_a.sel);
      chk("a_anode", anode_a, exp_anode(m_a, 4, 1'b1));
      chk("a_digit_strobe", ds_a, m_a.ds);
      chk("a_frame_tick", ft_a, m_a.ft);
      chk("b_sel", sel_b, m_b.sel);
      chk("b_anode", anode_b, exp_anode(m_b, 4, 1'b1));
      chk("b_digit_strobe", ds_b, m_b.ds);
      chk("b_frame_tick", ft_b, m_b.ft);
      chk("c_sel", sel_c, m_c.sel);
      chk("c_anode", anode_c, exp_anode(m_c, 3, 1'b0));
      chk("c_digit_strobe", ds_c, m_c.ds);
      chk("c_frame_tick", ft_c, m_c.ft);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mask = 4'b0000;

    // Reset held for three clocks, then released with scanning disabled.
    repeat (3) @(negedge clk);
    chk("rst_anode_a", anode_a, 4'b1111);
    chk("rst_sel_a", sel_a, 0);
    chk("rst_strobe_a", ds_a, 0);
    chk("rst_frame_a", ft_a, 0);
    chk("rst_anode_c", anode_c, 3'b000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_anode_a", anode_a, 4'b1111);
    chk("idle_strobe_a", ds_a, 0);

    // Full scan of four digits, 5 on + 2 blank per digit.
    en = 1'b1; mask = 4'b1111;
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      chk("t2_anode", anode_a, (c % 7 < 5) ? ((~(1 << ((c / 7) % 4))) & 15) : 15);
      chk("t2_sel", sel_a, (c / 7) % 4);
      chk("t2_dstrobe", ds_a, int'(c % 7 == 0));
      chk("t2_frame", ft_a, int'(c % 28 == 0));
      if (c == 0) chk("t6_anode_first", anode_c, 3'b001);
    end

    // Single digit: constant anode on the no-blank instance.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; mask = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t4_anode", anode_b, 4'b1011);
      chk("t4_sel", sel_b, 2);
      chk("t4_dstrobe", ds_b, int'(c % 5 == 0));
      chk("t4_frame", ft_b, int'(c % 5 == 0));
    end

    // Skip pattern: digits 1 and 3 only.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; mask = 4'b1010;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("t3_sel", sel_a, ((c / 7) % 2 == 0) ? 1 : 3);
      chk("t3_frame", ft_a, int'(c % 14 == 0));
    end

    // Clearing the current digit's mask bit mid-ON, then mask to zero.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; mask = 4'b1111;
    repeat (2) @(negedge clk);
    mask = 4'b1110;
    @(negedge clk);
    chk("t5_clear_anode", anode_a, 4'b1111);
    repeat (5) @(negedge clk);
    chk("t5_adv_strobe", ds_a, 1);
    chk("t5_adv_sel", sel_a, 1);
    mask = 4'b0000;
    repeat (10) @(negedge clk);
    chk("t5_mask0_anode", anode_a, 4'b1111);

    // Disable mid-BLANK, then re-enable restarts at the lowest digit.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; mask = 4'b1111;
    repeat (13) @(negedge clk);
    chk("t5_blank_anode", anode_a, 4'b1111);
    chk("t5_blank_sel", sel_a, 1);
    en = 1'b0;
    @(negedge clk);
    chk("t5_dis_anode", anode_a, 4'b1111);
    chk("t5_dis_sel_held", sel_a, 1);
    en = 1'b1;
    @(negedge clk);
    chk("t5_restart_sel", sel_a, 0);
    chk("t5_restart_strobe", ds_a, 1);

    // Random mix of mask changes, enable drops and reset pulses.
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 149) != 0);
      en    = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 24) == 0) mask = 4'($urandom_range(0, 15));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
